// File: rtl/axi_sub_mem_responder.sv
// AXI4 subordinate backed by a small word-addressed memory, with independent single-outstanding write and read engines.
// Optional feature macro AXI_SUB_RESP_STALL_EN: LFSR-driven wready/R-launch/bvalid stalls.
module axi_sub_mem_responder #(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned IW    = 8,
    parameter int unsigned DEPTH = 256
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            awvalid,
    output logic            awready,
    input  logic [AW-1:0]   awaddr,
    input  logic [IW-1:0]   awid,
    input  logic [7:0]      awlen,
    input  logic [1:0]      awburst,
    input  logic            wvalid,
    output logic            wready,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wstrb,
    input  logic            wlast,
    output logic            bvalid,
    input  logic            bready,
    output logic [1:0]      bresp,
    output logic [IW-1:0]   bid,
    input  logic            arvalid,
    output logic            arready,
    input  logic [AW-1:0]   araddr,
    input  logic [IW-1:0]   arid,
    input  logic [7:0]      arlen,
    input  logic [1:0]      arburst,
    output logic            rvalid,
    input  logic            rready,
    output logic [DW-1:0]   rdata,
    output logic [1:0]      rresp,
    output logic [IW-1:0]   rid,
    output logic            rlast
);

    localparam int unsigned NB   = DW / 8;
    localparam int unsigned LSB  = $clog2(NB);
    localparam int unsigned IDXW = $clog2(DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic logic burst_err(input logic [7:0] len, input logic [1:0] burst);
        return (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_len_ok(len));
    endfunction

    // Illegal WRAP lengths and the reserved type fall through to INCR.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr, input logic [7:0] len,
                                                input logic [1:0] burst);
        logic [AW-1:0] inc;
        logic [AW-1:0] mask;
        inc  = addr + AW'(NB);
        mask = ((AW'(len) + AW'(1)) * AW'(NB)) - AW'(1);
        if (burst == BURST_FIXED) return addr;
        if ((burst == BURST_WRAP) && wrap_len_ok(len)) return (addr & ~mask) | (inc & mask);
        return inc;
    endfunction

    function automatic logic out_of_range(input logic [AW-1:0] addr);
        return (addr >> (LSB + IDXW)) != '0;
    endfunction

    logic [DW-1:0] mem [DEPTH];

    logic stall_c;
    logic stall_nxt_c;

`ifdef AXI_SUB_RESP_STALL_EN
    logic [7:0] lfsr;
    logic [7:0] lfsr_nxt;

    assign lfsr_nxt    = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign stall_c     = lfsr[0];
    assign stall_nxt_c = lfsr_nxt[0];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) lfsr <= 8'hA5;
        else        lfsr <= lfsr_nxt;
    end
`else
    assign stall_c     = 1'b0;
    assign stall_nxt_c = 1'b0;
`endif

    // ---------------- write engine ----------------
    w_state_t        w_state, w_state_next;
    logic [AW-1:0]   w_addr;
    logic [7:0]      w_len;
    logic [7:0]      w_cnt;
    logic [1:0]      w_burst;
    logic            w_slv;
    logic            w_dec;
    logic            aw_hs, w_hs, b_hs;
    logic            w_oor_c;
    logic [IDXW-1:0] w_idx_c;

    assign aw_hs   = awvalid && awready && (w_state == W_IDLE);
    assign w_hs    = wvalid && wready && (w_state == W_DATA);
    assign b_hs    = bvalid && bready && (w_state == W_RESP);
    assign w_oor_c = out_of_range(w_addr);
    assign w_idx_c = w_addr[LSB +: IDXW];

    always_comb begin
        w_state_next = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_hs) w_state_next = W_DATA;
            W_DATA:  if (w_hs && wlast) w_state_next = W_RESP;
            W_RESP:  if (b_hs) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            bid     <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_burst <= '0;
            w_slv   <= 1'b0;
            w_dec   <= 1'b0;
        end else begin
            w_state <= w_state_next;
            awready <= (w_state_next == W_IDLE);
            wready  <= (w_state_next == W_DATA) && !stall_nxt_c;
            if (aw_hs) begin
                w_addr  <= awaddr;
                w_len   <= awlen;
                w_burst <= awburst;
                bid     <= awid;
                w_cnt   <= '0;
                w_slv   <= burst_err(awlen, awburst);
                w_dec   <= 1'b0;
            end
            if (w_hs) begin
                w_addr <= next_addr(w_addr, w_len, w_burst);
                w_cnt  <= w_cnt + 8'd1;
                if (w_oor_c) w_dec <= 1'b1;
                if (wlast) begin
                    bvalid <= !stall_c;
                    bresp  <= (w_dec || w_oor_c) ? RESP_DECERR :
                              ((w_slv || (w_cnt != w_len)) ? RESP_SLVERR : RESP_OKAY);
                end
            end
            // A stalled entry into W_RESP raises bvalid one cycle late.
            if (w_state == W_RESP) begin
                if (b_hs)         bvalid <= 1'b0;
                else if (!bvalid) bvalid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs && !w_oor_c) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (wstrb[b]) mem[w_idx_c][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    r_state_t        r_state, r_state_next;
    logic [AW-1:0]   r_addr;
    logic [7:0]      r_len;
    logic [8:0]      r_cnt;
    logic [1:0]      r_burst;
    logic            r_slv;
    logic            ar_hs, r_hs;
    logic            r_launch_c;
    logic [AW-1:0]   rb_addr_c;
    logic [7:0]      rb_len_c;
    logic [1:0]      rb_burst_c;
    logic            rb_slv_c;
    logic [7:0]      rb_num_c;
    logic            rb_oor_c;
    logic [IDXW-1:0] rb_idx_c;

    assign ar_hs    = arvalid && arready && (r_state == R_IDLE);
    assign r_hs     = rvalid && rready;
    assign rb_oor_c = out_of_range(rb_addr_c);
    assign rb_idx_c = rb_addr_c[LSB +: IDXW];

    // Beat 0 launches straight off the AR handshake; later beats launch when the R slot frees up.
    always_comb begin
        r_state_next = r_state;
        r_launch_c   = 1'b0;
        rb_addr_c    = r_addr;
        rb_len_c     = r_len;
        rb_burst_c   = r_burst;
        rb_slv_c     = r_slv;
        rb_num_c     = r_cnt[7:0];
        unique case (r_state)
            R_IDLE: begin
                rb_addr_c  = araddr;
                rb_len_c   = arlen;
                rb_burst_c = arburst;
                rb_slv_c   = burst_err(arlen, arburst);
                rb_num_c   = 8'd0;
                if (ar_hs) begin
                    r_state_next = R_DATA;
                    r_launch_c   = !stall_c;
                end
            end
            R_DATA: begin
                if (r_hs && rlast) r_state_next = R_IDLE;
                else if ((!rvalid || r_hs) && (r_cnt <= {1'b0, r_len})) r_launch_c = !stall_c;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            rid     <= '0;
            rlast   <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_burst <= '0;
            r_slv   <= 1'b0;
        end else begin
            r_state <= r_state_next;
            arready <= (r_state_next == R_IDLE);
            if (ar_hs) begin
                r_len   <= arlen;
                r_burst <= arburst;
                r_slv   <= burst_err(arlen, arburst);
                rid     <= arid;
                r_addr  <= araddr;
                r_cnt   <= '0;
            end
            if (r_launch_c) begin
                rvalid <= 1'b1;
                rdata  <= rb_oor_c ? '0 : mem[rb_idx_c];
                rresp  <= rb_oor_c ? RESP_DECERR : (rb_slv_c ? RESP_SLVERR : RESP_OKAY);
                rlast  <= (rb_num_c == rb_len_c);
                r_addr <= next_addr(rb_addr_c, rb_len_c, rb_burst_c);
                r_cnt  <= 9'(rb_num_c) + 9'd1;
            end else if (r_hs) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_sub_mem_responder.sv
// Self-checking bench for axi_sub_mem_responder: directed scenarios plus randomized bursts against a byte-level memory model.
module tb_axi_sub_mem_responder;

    localparam int unsigned AW        = 32;
    localparam int unsigned DW        = 32;
    localparam int unsigned IW        = 8;
    localparam int unsigned DEPTH     = 256;
    localparam int unsigned NB        = DW / 8;
    localparam int unsigned MEM_BYTES = DEPTH * NB;
    localparam int unsigned BUDGET    = 200;

    logic            clk = 1'b0;
    logic            rst_b;
    logic            awvalid, awready;
    logic [AW-1:0]   awaddr;
    logic [IW-1:0]   awid;
    logic [7:0]      awlen;
    logic [1:0]      awburst;
    logic            wvalid, wready;
    logic [DW-1:0]   wdata;
    logic [NB-1:0]   wstrb;
    logic            wlast;
    logic            bvalid, bready;
    logic [1:0]      bresp;
    logic [IW-1:0]   bid;
    logic            arvalid, arready;
    logic [AW-1:0]   araddr;
    logic [IW-1:0]   arid;
    logic [7:0]      arlen;
    logic [1:0]      arburst;
    logic            rvalid, rready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic [IW-1:0]   rid;
    logic            rlast;

    always #5 clk = ~clk;

    axi_sub_mem_responder #(.AW(AW), .DW(DW), .IW(IW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_b(rst_b),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast)
    );

    logic [DW-1:0] mdl [DEPTH];
    logic [DW-1:0] wd_q [$];
    logic [NB-1:0] ws_q [$];
    int unsigned   n_checks = 0;
    int unsigned   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit wrap_ok(input int unsigned len);
        return (len == 1) || (len == 3) || (len == 7) || (len == 15);
    endfunction

    // Byte address of beat i, straight from the burst rules.
    function automatic int unsigned beat_addr(input int unsigned a, input int unsigned len,
                                              input int unsigned burst, input int unsigned i);
        int unsigned bound, base;
        if (burst == 0) return a;
        if (burst == 2 && wrap_ok(len)) begin
            bound = (len + 1) * NB;
            base  = (a / bound) * bound;
            return base + ((a - base) + i * NB) % bound;
        end
        return a + i * NB;
    endfunction

    function automatic bit flagged(input int unsigned len, input int unsigned burst);
        return (burst == 3) || (burst == 2 && !wrap_ok(len));
    endfunction

    // Sends the beats queued in wd_q/ws_q (wlast on the final one) and checks the B response.
    task automatic axi_write(input logic [AW-1:0] addr, input logic [IW-1:0] id, input logic [7:0] len,
                             input logic [1:0] burst);
        int unsigned n, cnt, a;
        bit          dec, slv;
        logic [1:0]  exp_resp;
        n = wd_q.size();
        awaddr = addr; awid = id; awlen = len; awburst = burst; awvalid = 1'b1;
        cnt = 0;
        while (!awready && cnt < BUDGET) begin tick(); cnt++; end
        if (cnt >= BUDGET) check("aw_timeout", 64'(0), 64'(1));
        tick();
        awvalid = 1'b0;
        dec = 1'b0;
        slv = flagged(32'(len), 32'(burst));
        for (int unsigned i = 0; i < n; i++) begin
            a = beat_addr(addr, 32'(len), 32'(burst), i);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) tick();
            wvalid = 1'b1; wdata = wd_q[i]; wstrb = ws_q[i]; wlast = (i == n - 1);
            cnt = 0;
            while (!wready && cnt < BUDGET) begin tick(); cnt++; end
            if (cnt >= BUDGET) check("w_timeout", 64'(0), 64'(1));
            tick();
            wvalid = 1'b0; wlast = 1'b0;
            if (a >= MEM_BYTES) dec = 1'b1;
            else for (int b = 0; b < int'(NB); b++) if (ws_q[i][b]) mdl[a / NB][8*b +: 8] = wd_q[i][8*b +: 8];
        end
        if (n != 32'(len) + 1) slv = 1'b1;
        exp_resp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
        cnt = 0;
        while (!bvalid && cnt < BUDGET) begin tick(); cnt++; end
        if (cnt >= BUDGET) check("b_timeout", 64'(0), 64'(1));
        repeat ($urandom_range(0, 2)) tick();
        check("bvalid_hold", 64'(bvalid), 64'(1));
        check("bresp", 64'(bresp), 64'(exp_resp));
        check("bid", 64'(bid), 64'(id));
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("awready_after_b", 64'(awready), 64'(1));
        wd_q.delete();
        ws_q.delete();
    endtask

    task automatic ar_issue(input logic [AW-1:0] addr, input logic [IW-1:0] id, input logic [7:0] len,
                            input logic [1:0] burst);
        int unsigned cnt;
        araddr = addr; arid = id; arlen = len; arburst = burst; arvalid = 1'b1;
        cnt = 0;
        while (!arready && cnt < BUDGET) begin tick(); cnt++; end
        if (cnt >= BUDGET) check("ar_timeout", 64'(0), 64'(1));
        tick();
        arvalid = 1'b0;
    endtask

    // Waits for, checks and accepts beat i of a read burst.
    task automatic r_beat(input logic [AW-1:0] addr, input logic [IW-1:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input int unsigned i);
        int unsigned   cnt, a;
        logic [DW-1:0] exp_d;
        logic [1:0]    exp_r;
        a     = beat_addr(addr, 32'(len), 32'(burst), i);
        exp_d = (a >= MEM_BYTES) ? '0 : mdl[a / NB];
        exp_r = (a >= MEM_BYTES) ? 2'b11 : (flagged(32'(len), 32'(burst)) ? 2'b10 : 2'b00);
        cnt = 0;
        while (!rvalid && cnt < BUDGET) begin tick(); cnt++; end
        if (cnt >= BUDGET) check("r_timeout", 64'(0), 64'(1));
        repeat ($urandom_range(0, 2)) tick();
        check("rdata", 64'(rdata), 64'(exp_d));
        check("rresp", 64'(rresp), 64'(exp_r));
        check("rid", 64'(rid), 64'(id));
        check("rlast", 64'(rlast), 64'(i == 32'(len)));
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input logic [IW-1:0] id, input logic [7:0] len,
                            input logic [1:0] burst);
        ar_issue(addr, id, len, burst);
`ifndef AXI_SUB_RESP_STALL_EN
        check("r_latency", 64'(rvalid), 64'(1));
`endif
        for (int unsigned i = 0; i <= 32'(len); i++) begin
            r_beat(addr, id, len, burst, i);
`ifndef AXI_SUB_RESP_STALL_EN
            if (i < 32'(len)) check("r_throughput", 64'(rvalid), 64'(1));
`endif
        end
        check("arready_after_r", 64'(arready), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]    len;
        logic [1:0]    burst;
        logic [AW-1:0] addr;
        int unsigned   n;

        rst_b = 1'b0;
        awvalid = 1'b0; awaddr = '0; awid = '0; awlen = '0; awburst = '0;
        wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b0;
        arvalid = 1'b0; araddr = '0; arid = '0; arlen = '0; arburst = '0; rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 64'(awready), 64'(0));
        check("rst_wready", 64'(wready), 64'(0));
        check("rst_bvalid", 64'(bvalid), 64'(0));
        check("rst_arready", 64'(arready), 64'(0));
        check("rst_rvalid", 64'(rvalid), 64'(0));
        check("rst_rdata", 64'(rdata), 64'(0));
        @(negedge clk);
        rst_b = 1'b1;
        tick();
        check("rel_awready", 64'(awready), 64'(1));
        check("rel_arready", 64'(arready), 64'(1));

        // Preload every word so all later reads have known contents.
        for (int unsigned i = 0; i < DEPTH; i++) begin wd_q.push_back(DW'($urandom)); ws_q.push_back('1); end
        axi_write(32'h0, 8'h01, 8'd255, 2'b01);

        // INCR write then readback.
        wd_q = '{32'h11, 32'h22, 32'h33, 32'h44};
        ws_q = '{4'hF, 4'hF, 4'hF, 4'hF};
        axi_write(32'h10, 8'h3C, 8'd3, 2'b01);
        axi_read(32'h10, 8'hC3, 8'd3, 2'b01);

        // WRAP read starting mid-window.
        axi_read(32'h18, 8'h21, 8'd3, 2'b10);

        // Burst running off the end of memory.
        wd_q = '{32'hCAFE_0001, 32'hCAFE_0002};
        ws_q = '{4'hF, 4'hF};
        axi_write(AW'(MEM_BYTES - 4), 8'h77, 8'd1, 2'b01);
        axi_read(AW'(MEM_BYTES - 4), 8'h78, 8'd1, 2'b01);

        // Partial strobes over a zeroed word.
        wd_q = '{32'h0};
        ws_q = '{4'hF};
        axi_write(32'h40, 8'h02, 8'd0, 2'b01);
        wd_q = '{32'hAABB_CCDD};
        ws_q = '{4'b0101};
        axi_write(32'h40, 8'h03, 8'd0, 2'b01);
        axi_read(32'h40, 8'h04, 8'd0, 2'b01);

        // Early wlast: two beats sent on a four-beat burst.
        wd_q = '{32'h5555_0000, 32'h5555_0001};
        ws_q = '{4'hF, 4'hF};
        axi_write(32'h80, 8'h05, 8'd3, 2'b01);
        axi_read(32'h80, 8'h06, 8'd3, 2'b01);

        // Reset in the middle of a read burst.
        ar_issue(32'h100, 8'h5A, 8'd7, 2'b01);
        r_beat(32'h100, 8'h5A, 8'd7, 2'b01, 0);
        r_beat(32'h100, 8'h5A, 8'd7, 2'b01, 1);
        rst_b = 1'b0;
        #1;
        check("midrst_rvalid", 64'(rvalid), 64'(0));
        check("midrst_arready", 64'(arready), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        tick();
        check("midrst_rel_arready", 64'(arready), 64'(1));
        axi_read(32'h100, 8'h5B, 8'd3, 2'b01);

        // Randomized mix of reads and writes, including out-of-range and flagged bursts.
        for (int t = 0; t < 40; t++) begin
            burst = 2'($urandom_range(0, 3));
            if (burst == 2'b10 && $urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 3))
                    0:       len = 8'd1;
                    1:       len = 8'd3;
                    2:       len = 8'd7;
                    default: len = 8'd15;
                endcase
            end else begin
                len = 8'($urandom_range(0, 15));
            end
            addr = AW'($urandom_range(0, 32'h13F) * 4);
            if ($urandom_range(0, 1) == 0) begin
                n = 32'(len) + 1;
                if (len != 0 && $urandom_range(0, 5) == 0) n = $urandom_range(1, 32'(len));
                for (int unsigned i = 0; i < n; i++) begin
                    wd_q.push_back(DW'($urandom));
                    ws_q.push_back(NB'($urandom));
                end
                axi_write(addr, IW'($urandom), len, burst);
            end else begin
                axi_read(addr, IW'($urandom), len, burst);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_sub_mem_responder.md
Name: axi_sub_mem_responder

Overview:
AXI4 subordinate (responder) with a small internal word-addressed memory. It is the far end for the AXI initiator test sequences in the Caliptra SS integration bench. It accepts AW/W bursts and AR bursts, returns B and R responses with echoed IDs, and flags protocol and decode errors. Write and read paths are independent single-outstanding engines.

Parameters:
AW, 32, address width
DW, 32, data width (64 is also legal); every transfer is full width and AxSIZE is not ported
IW, 8, ID width
DEPTH, 256, memory depth in DW-bit words (power of 2)

Ports:
clk  in  1  clock
rst_b  in  1  asynchronous active-low reset
awvalid  in  1  write address valid
awready  out  1  write address ready
awaddr  in  AW  burst start byte address
awid  in  IW  write ID
awlen  in  8  beats minus 1
awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
wvalid  in  1  write data valid
wready  out  1  write data ready
wdata  in  DW  write data
wstrb  in  DW/8  byte strobes
wlast  in  1  last write beat
bvalid  out  1  write response valid
bready  in  1  write response ready
bresp  out  2  write response
bid  out  IW  echoed awid
arvalid  in  1  read address valid
arready  out  1  read address ready
araddr  in  AW  burst start byte address
arid  in  IW  read ID
arlen  in  8  beats minus 1
arburst  in  2  burst type
rvalid  out  1  read data valid
rready  in  1  read data ready
rdata  out  DW  read data
rresp  out  2  read response
rid  out  IW  echoed arid
rlast  out  1  last read beat

Behaviour:
- Reset (rst_b low, asynchronous): all outputs 0, both FSMs idle. Memory contents are retained (not reset). awready and arready rise in the first clk after rst_b deasserts. Reset mid-burst abandons the burst with no response.
- Write FSM W_IDLE -> W_DATA -> W_RESP.
  - W_IDLE: awready=1. On AW handshake, latch addr/id/len/burst, clear the error flag, go to W_DATA; wready=1 from the next cycle.
  - W_DATA: each W handshake writes the bytes enabled by wstrb to word addr[log2(DW/8) +: log2(DEPTH)], increments the beat counter and advances addr. The wlast handshake moves to W_RESP and asserts bvalid the next cycle.
  - W_RESP: bvalid, bid and bresp are held stable until bready, then return to W_IDLE (awready=1 the next cycle).
- Read FSM R_IDLE -> R_DATA.
  - R_IDLE: arready=1. AR handshake in cycle N gives rvalid in N+1.
  - R_DATA: rdata, rresp, rid and rlast are registered and held stable while rvalid=1 and rready=0. Each R handshake presents the next beat in the following cycle (full throughput). rlast=1 on beat arlen. The rlast handshake returns to R_IDLE.
- Address generation:
  - FIXED: addr unchanged.
  - INCR: addr += DW/8.
  - WRAP: boundary = (len+1)*DW/8, aligned to a multiple of the boundary; addr wraps to the lower boundary. WRAP with len not in {1,3,7,15} is handled as INCR and flagged SLVERR.
  - Burst type 11: handled as INCR and flagged SLVERR.
- Errors: response codes are OKAY=00, SLVERR=10, DECERR=11.
  - Out-of-range beat (byte addr >= DEPTH*DW/8): write is dropped; read returns 0 with rresp DECERR for that beat.
  - Write bresp priority: DECERR if any beat was out of range, else SLVERR if flagged or if wlast arrived at a beat count != awlen+1, else OKAY.
  - Read rresp is SLVERR on every beat of a flagged burst (DECERR wins per beat).
- Write/read collision: a read beat registered in the same cycle as a write to the same word returns the old data. The next beat sees the new data.

Optional Feature:
Macro AXI_SUB_RESP_STALL_EN.
- Defined: an 8-bit LFSR (seed 8'hA5, x^8+x^6+x^5+x^4+1) advances every clk. When lfsr[0]=1, wready is forced 0 and no new R beat is launched. An already-asserted rvalid stays asserted with stable payload. bvalid is delayed by one cycle if lfsr[0]=1 when W_RESP is entered.
- Undefined: no stalls; latencies exactly as stated in Behaviour.

Test Plan:
- INCR write awaddr=0x10, awlen=3, data 0x11..0x44, wstrb=F, then INCR read of the same range -> bresp=00 and bid=awid; rdata 0x11,0x22,0x33,0x44; rlast only on beat 3; rvalid one cycle after the AR handshake.
- WRAP read araddr=0x18, arlen=3 (DW=32) -> beat addresses 0x18,0x1C,0x10,0x14; rresp=00.
- Write awaddr=DEPTH*4-4, awlen=1 (INCR) -> beat 0 written, beat 1 dropped, bresp=11. Read of the same range -> beat 0 data with rresp=00, beat 1 data 0 with rresp=11.
- Partial strobe: write 0xAABBCCDD with wstrb=4'b0101 over a word holding 0 -> readback 0x00BB00DD.
- Early wlast on beat 1 with awlen=3 -> bresp=10; memory holds the 2 written beats.
- Assert rst_b low mid read burst, after beat 1 -> rvalid=0 immediately. After release, arready=1 within 1 cycle and a new read returns correct data.
